cv32e40p_alu_reconf_ctrl_ft: RTL and testbench
==============================================

CV32E40P_ALU_RECONF_CTRL_FT -- requirements
Module: cv32e40p_alu_reconf_ctrl_ft

Interface
REQ-001 Parameter N_ALU, default 4: number of redundant ALUs; only 4 is supported.
REQ-002 Parameter N_CLASS, default 9: number of op classes, in order shift/add=0, logic=1, bit_man=2, bit_count=3, shuf=4, comparison=5, abs=6, min_max=7, div_rem=8.
REQ-003 clk  in  1  core clock; one clock domain.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 permanent_faulty_alu_i  in  [3:0][8:0]  per-ALU, per-class sticky permanent-fault flags from the error counter.
REQ-006 alu_valid_i  in  1  an ALU op is issued this cycle.
REQ-007 alu_operator_i  in  ALU_OP_WIDTH  operator of the issued op.
REQ-008 pipe_idle_i  in  1  EX stage is drained; acknowledges stall.
REQ-009 reconf_stall_o  out  1  request to hold issue while the table is rebuilt.
REQ-010 alu_sel_o  out  4  mask of ALUs to execute the op.
REQ-011 vote_mode_o  out  2  voting mode: NONE=0, SINGLE=1, DMR=2, TMR=3.
REQ-012 sel_valid_o  out  1  alu_sel_o and vote_mode_o are valid.
REQ-013 clock_en_o  out  4  clock enables for the error-counter lanes.
REQ-014 no_alu_o  out  1  at least one class has no healthy ALU.

Function
REQ-015 Operator-to-class decode SHALL use the fixed operator grouping of the error counter; any other operator maps to class OTHER.
REQ-016 Snapshot register faulty_q SHALL hold the fault vector the table was built from; a fault change is any cycle where permanent_faulty_alu_i != faulty_q.
REQ-017 The FSM SHALL have three states: RUN, DRAIN, REBUILD.
REQ-018 RUN->DRAIN on a fault change; faulty_q is loaded in the same cycle.
REQ-019 DRAIN: reconf_stall_o=1; on pipe_idle_i=1, go to REBUILD with idx=0; a further fault change reloads faulty_q and stays in DRAIN.
REQ-020 REBUILD: reconf_stall_o=1; write one table entry per cycle for class idx, idx 0..8; after idx=8 is written, go to RUN (9 cycles total).
REQ-021 A fault change during REBUILD SHALL reload faulty_q and restart at idx=0 without leaving REBUILD.
REQ-022 Entry for class c: healthy set is the ALUs k with faulty_q[k][c]=0, with h = number of healthy ALUs; the entry is filled as follows.
- h>=3: the 3 lowest-index healthy ALUs, TMR.
- h=2: both, DMR.
- h=1: that ALU, SINGLE.
- h=0: mask 0, NONE.
REQ-023 In RUN, alu_valid_i=1 SHALL give one-cycle latency: the next cycle has sel_valid_o=1, alu_sel_o=table[class], vote_mode_o=entry mode. Class OTHER gives 4'b0111, TMR.
REQ-024 alu_valid_i in DRAIN/REBUILD SHALL be ignored; sel_valid_o=0 the next cycle.
REQ-025 clock_en_o SHALL equal alu_sel_o when sel_valid_o=1, and 0 otherwise.
REQ-026 no_alu_o SHALL be registered: the OR over all entries with mode NONE, updated as entries are written.

Reset
REQ-027 On rst_n=0, asynchronously:
- state=RUN, faulty_q=0, idx=0.
- every table entry = 4'b0111, TMR.
- sel_valid_o=0, alu_sel_o=0, vote_mode_o=NONE, clock_en_o=0, reconf_stall_o=0, no_alu_o=0.
REQ-028 Reset mid-REBUILD SHALL discard the partial table; after release, a nonzero fault input triggers a full DRAIN/REBUILD.

Structure
REQ-029 The op-class enum, vote-mode enum, N_CLASS and TMR_WIDTH=3 SHALL live in cv32e40p_pkg.
REQ-030 Operator decode SHALL be one combinational sub-module, cv32e40p_alu_class_decode_ft, shared with the error counter.

Verification
REQ-031 Reset, no faults, ALU_ADD valid -> next cycle alu_sel_o=0111, TMR, clock_en_o=0111, sel_valid_o=1.
REQ-032 Set faulty[1][1]=1, pipe_idle_i held 0 for 5 cycles, then 1 -> required response:
- reconf_stall_o=1 from the next cycle, through DRAIN plus 9 REBUILD cycles;
- then ALU_XOR gives 1101/TMR and ALU_ADD gives 0111/TMR.
REQ-033 Faults at faulty[0][8], [1][8], [2][8] after rebuild, ALU_DIV -> alu_sel_o=1000, SINGLE; no_alu_o=0.
REQ-034 All four ALUs faulty in class 5, ALU_EQ after rebuild -> alu_sel_o=0000, NONE, no_alu_o=1, clock_en_o=0.
REQ-035 New fault at REBUILD idx=4 -> idx restarts at 0; stall lasts 9 cycles from the restart; the final table reflects both faults.
REQ-036 rst_n low at REBUILD idx=3 -> table back to 0111/TMR, stall=0; after release, the fault input still set -> full DRAIN plus 9-cycle REBUILD.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared ALU fault-tolerance definitions: operator encoding, op classes, vote modes
// and the rule that turns a per-class healthy-ALU set into a selection entry.
package cv32e40p_pkg;

    localparam int unsigned ALU_OP_WIDTH = 7;
    localparam int unsigned N_CLASS      = 9;
    localparam int unsigned TMR_WIDTH    = 3;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD   = 7'b0011000, ALU_SUB   = 7'b0011001, ALU_ADDU  = 7'b0011010, ALU_SUBU  = 7'b0011011,
        ALU_ADDR  = 7'b0011100, ALU_SUBR  = 7'b0011101, ALU_ADDUR = 7'b0011110, ALU_SUBUR = 7'b0011111,
        ALU_SRA   = 7'b0100100, ALU_SRL   = 7'b0100101, ALU_ROR   = 7'b0100110, ALU_SLL   = 7'b0100111,
        ALU_XOR   = 7'b0101111, ALU_OR    = 7'b0101110, ALU_AND   = 7'b0010101,
        ALU_BEXT  = 7'b0101000, ALU_BEXTU = 7'b0101001, ALU_BINS  = 7'b0101010, ALU_BCLR  = 7'b0101011,
        ALU_BSET  = 7'b0101100, ALU_BREV  = 7'b1001001,
        ALU_FF1   = 7'b0110110, ALU_FL1   = 7'b0110111, ALU_CNT   = 7'b0110100, ALU_CLB   = 7'b0110101,
        ALU_SHUF  = 7'b0111010, ALU_SHUF2 = 7'b0111011, ALU_PCKLO = 7'b0111000, ALU_PCKHI = 7'b0111001,
        ALU_EXTS  = 7'b0111110, ALU_EXT   = 7'b0111111, ALU_INS   = 7'b0101101,
        ALU_LTS   = 7'b0000000, ALU_LTU   = 7'b0000001, ALU_SLTS  = 7'b0000010, ALU_SLTU  = 7'b0000011,
        ALU_LES   = 7'b0000100, ALU_LEU   = 7'b0000101, ALU_SLETS = 7'b0000110, ALU_SLETU = 7'b0000111,
        ALU_GTS   = 7'b0001000, ALU_GTU   = 7'b0001001, ALU_GES   = 7'b0001010, ALU_GEU   = 7'b0001011,
        ALU_EQ    = 7'b0001100, ALU_NE    = 7'b0001101,
        ALU_ABS   = 7'b0010100, ALU_CLIP  = 7'b0010110, ALU_CLIPU = 7'b0010111,
        ALU_MIN   = 7'b0010000, ALU_MINU  = 7'b0010001, ALU_MAX   = 7'b0010010, ALU_MAXU  = 7'b0010011,
        ALU_DIVU  = 7'b0110000, ALU_DIV   = 7'b0110001, ALU_REMU  = 7'b0110010, ALU_REM   = 7'b0110011
    } alu_opcode_e;

    typedef enum logic [3:0] {
        CLS_SHIFT_ADD  = 4'd0,
        CLS_LOGIC      = 4'd1,
        CLS_BIT_MAN    = 4'd2,
        CLS_BIT_COUNT  = 4'd3,
        CLS_SHUF       = 4'd4,
        CLS_COMPARISON = 4'd5,
        CLS_ABS        = 4'd6,
        CLS_MIN_MAX    = 4'd7,
        CLS_DIV_REM    = 4'd8,
        CLS_OTHER      = 4'd9
    } alu_class_e;

    typedef enum logic [1:0] {
        VOTE_NONE   = 2'd0,
        VOTE_SINGLE = 2'd1,
        VOTE_DMR    = 2'd2,
        VOTE_TMR    = 2'd3
    } vote_mode_e;

    typedef struct packed {
        logic [3:0] sel;
        vote_mode_e mode;
    } alu_sel_entry_t;

    localparam alu_sel_entry_t RESET_ENTRY = '{sel: 4'b0111, mode: VOTE_TMR};

    function automatic alu_sel_entry_t build_entry(input logic [3:0] healthy);
        alu_sel_entry_t entry;
        logic [1:0]     picked;
        entry  = '{sel: '0, mode: VOTE_NONE};
        picked = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (healthy[k] && picked != 2'(TMR_WIDTH)) begin
                entry.sel[k] = 1'b1;
                picked       = picked + 2'd1;
            end
        end
        // Vote-mode encoding is the number of lanes selected.
        entry.mode = vote_mode_e'(picked);
        return entry;
    endfunction

endpackage

// File: rtl/cv32e40p_alu_reconf_ctrl_ft_if.sv
// Issue/selection handshake between the core issue logic and the ALU reconfiguration controller.
interface cv32e40p_alu_reconf_ctrl_ft_if;
    import cv32e40p_pkg::*;

    logic                    alu_valid_i;
    logic [ALU_OP_WIDTH-1:0] alu_operator_i;
    logic                    pipe_idle_i;
    logic                    reconf_stall_o;
    logic [3:0]              alu_sel_o;
    vote_mode_e              vote_mode_o;
    logic                    sel_valid_o;
    logic [3:0]              clock_en_o;

    modport master (
        output alu_valid_i, alu_operator_i, pipe_idle_i,
        input  reconf_stall_o, alu_sel_o, vote_mode_o, sel_valid_o, clock_en_o
    );

    modport slave (
        input  alu_valid_i, alu_operator_i, pipe_idle_i,
        output reconf_stall_o, alu_sel_o, vote_mode_o, sel_valid_o, clock_en_o
    );

endinterface

// File: rtl/cv32e40p_alu_class_decode_ft.sv
// Maps an ALU operator onto its redundancy op class; shared with the error counter.
module cv32e40p_alu_class_decode_ft
    import cv32e40p_pkg::*;
(
    input  logic [ALU_OP_WIDTH-1:0] alu_operator_i,
    output alu_class_e              op_class_o
);

    always_comb begin
        op_class_o = CLS_OTHER;
        case (alu_operator_i)
            ALU_ADD, ALU_SUB, ALU_ADDU, ALU_SUBU, ALU_ADDR, ALU_SUBR, ALU_ADDUR, ALU_SUBUR,
            ALU_SRA, ALU_SRL, ALU_ROR, ALU_SLL:
                op_class_o = CLS_SHIFT_ADD;
            ALU_XOR, ALU_OR, ALU_AND:
                op_class_o = CLS_LOGIC;
            ALU_BEXT, ALU_BEXTU, ALU_BINS, ALU_BCLR, ALU_BSET, ALU_BREV:
                op_class_o = CLS_BIT_MAN;
            ALU_FF1, ALU_FL1, ALU_CNT, ALU_CLB:
                op_class_o = CLS_BIT_COUNT;
            ALU_SHUF, ALU_SHUF2, ALU_PCKLO, ALU_PCKHI, ALU_EXTS, ALU_EXT, ALU_INS:
                op_class_o = CLS_SHUF;
            ALU_LTS, ALU_LTU, ALU_SLTS, ALU_SLTU, ALU_LES, ALU_LEU, ALU_SLETS, ALU_SLETU,
            ALU_GTS, ALU_GTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE:
                op_class_o = CLS_COMPARISON;
            ALU_ABS, ALU_CLIP, ALU_CLIPU:
                op_class_o = CLS_ABS;
            ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU:
                op_class_o = CLS_MIN_MAX;
            ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM:
                op_class_o = CLS_DIV_REM;
            default:
                op_class_o = CLS_OTHER;
        endcase
    end

endmodule

// File: rtl/cv32e40p_alu_reconf_ctrl_ft.sv
// Rebuilds the per-class ALU selection table when the permanent-fault map changes,
// and steers each issued op to its redundant ALU set with one cycle of latency.
module cv32e40p_alu_reconf_ctrl_ft #(
    parameter int unsigned N_ALU   = 4,
    parameter int unsigned N_CLASS = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_ALU-1:0][N_CLASS-1:0] permanent_faulty_alu_i,
    cv32e40p_alu_reconf_ctrl_ft_if.slave  alu_if,
    output logic                          no_alu_o
);
    import cv32e40p_pkg::*;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_REBUILD = 2'd2
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(N_CLASS - 1);

    state_e                          state_q, state_d;
    logic [N_ALU-1:0][N_CLASS-1:0]   faulty_q, faulty_d;
    logic [3:0]                      idx_q, idx_d;
    alu_sel_entry_t [N_CLASS-1:0]    tbl_q, tbl_d;
    logic                            sel_valid_q, sel_valid_d;
    alu_sel_entry_t                  sel_q, sel_d;
    logic                            no_alu_q, no_alu_d;
    alu_class_e                      op_class;
    logic                            fault_change;
    logic [N_ALU-1:0]                healthy;

    cv32e40p_alu_class_decode_ft u_class_decode (
        .alu_operator_i (alu_if.alu_operator_i),
        .op_class_o     (op_class)
    );

    assign fault_change = (permanent_faulty_alu_i != faulty_q);

    always_comb begin
        healthy = '0;
        for (int unsigned k = 0; k < N_ALU; k++) begin
            healthy[k] = ~faulty_q[k][idx_q];
        end
    end

    always_comb begin
        state_d  = state_q;
        faulty_d = faulty_q;
        idx_d    = idx_q;
        tbl_d    = tbl_q;
        unique case (state_q)
            ST_RUN: begin
                if (fault_change) begin
                    faulty_d = permanent_faulty_alu_i;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fault_change) begin
                    faulty_d = permanent_faulty_alu_i;
                end else if (alu_if.pipe_idle_i) begin
                    state_d = ST_REBUILD;
                    idx_d   = '0;
                end
            end
            ST_REBUILD: begin
                // A fault arriving mid-rebuild restarts from class 0 so the table is never mixed.
                if (fault_change) begin
                    faulty_d = permanent_faulty_alu_i;
                    idx_d    = '0;
                end else begin
                    tbl_d[idx_q] = build_entry(healthy);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        sel_valid_d = 1'b0;
        sel_d       = '{sel: '0, mode: VOTE_NONE};
        if (state_q == ST_RUN && alu_if.alu_valid_i) begin
            sel_valid_d = 1'b1;
            sel_d       = (op_class == CLS_OTHER) ? RESET_ENTRY : tbl_q[op_class];
        end
        no_alu_d = 1'b0;
        for (int unsigned c = 0; c < N_CLASS; c++) begin
            no_alu_d = no_alu_d | (tbl_d[c].mode == VOTE_NONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            faulty_q    <= '0;
            idx_q       <= '0;
            for (int unsigned c = 0; c < N_CLASS; c++) begin
                tbl_q[c] <= RESET_ENTRY;
            end
            sel_valid_q <= 1'b0;
            sel_q       <= '{sel: '0, mode: VOTE_NONE};
            no_alu_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            faulty_q    <= faulty_d;
            idx_q       <= idx_d;
            tbl_q       <= tbl_d;
            sel_valid_q <= sel_valid_d;
            sel_q       <= sel_d;
            no_alu_q    <= no_alu_d;
        end
    end

    assign alu_if.reconf_stall_o = (state_q != ST_RUN);
    assign alu_if.sel_valid_o    = sel_valid_q;
    assign alu_if.alu_sel_o      = sel_q.sel;
    assign alu_if.vote_mode_o    = sel_q.mode;
    assign alu_if.clock_en_o     = sel_valid_q ? sel_q.sel : '0;
    assign no_alu_o              = no_alu_q;

endmodule

// File: tb/tb_cv32e40p_alu_reconf_ctrl_ft.sv
// Randomised and directed bench for the ALU reconfiguration controller against a
// cycle-level reference model of the fault-map / rebuild / issue rules.
module tb_cv32e40p_alu_reconf_ctrl_ft;
    import cv32e40p_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0][8:0] faulty;
    logic            no_alu;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned stall_seen;

    cv32e40p_alu_reconf_ctrl_ft_if alu_if ();

    cv32e40p_alu_reconf_ctrl_ft #(
        .N_ALU   (4),
        .N_CLASS (9)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .permanent_faulty_alu_i (faulty),
        .alu_if                 (alu_if),
        .no_alu_o               (no_alu)
    );

    always #5 clk = ~clk;

    // Reference model state: class of each opcode (9 = other), table, snapshot, phase.
    int              op_class [128];
    alu_opcode_e     known [$];
    logic [3:0]      m_sel [9];
    int              m_mode [9];
    logic [3:0][8:0] m_snap;
    bit              m_busy;
    int              m_rb;       // -1: waiting for drain, else next class to write
    bit              e_valid;
    logic [3:0]      e_sel;
    int              e_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic map(input alu_opcode_e op, input int c);
        op_class[op] = c;
        known.push_back(op);
    endtask

    task automatic init_map();
        foreach (op_class[i]) op_class[i] = 9;
        map(ALU_ADD, 0); map(ALU_SUB, 0); map(ALU_ADDU, 0); map(ALU_SUBU, 0);
        map(ALU_ADDR, 0); map(ALU_SUBR, 0); map(ALU_ADDUR, 0); map(ALU_SUBUR, 0);
        map(ALU_SRA, 0); map(ALU_SRL, 0); map(ALU_ROR, 0); map(ALU_SLL, 0);
        map(ALU_XOR, 1); map(ALU_OR, 1); map(ALU_AND, 1);
        map(ALU_BEXT, 2); map(ALU_BEXTU, 2); map(ALU_BINS, 2); map(ALU_BCLR, 2);
        map(ALU_BSET, 2); map(ALU_BREV, 2);
        map(ALU_FF1, 3); map(ALU_FL1, 3); map(ALU_CNT, 3); map(ALU_CLB, 3);
        map(ALU_SHUF, 4); map(ALU_SHUF2, 4); map(ALU_PCKLO, 4); map(ALU_PCKHI, 4);
        map(ALU_EXTS, 4); map(ALU_EXT, 4); map(ALU_INS, 4);
        map(ALU_LTS, 5); map(ALU_LTU, 5); map(ALU_SLTS, 5); map(ALU_SLTU, 5);
        map(ALU_LES, 5); map(ALU_LEU, 5); map(ALU_SLETS, 5); map(ALU_SLETU, 5);
        map(ALU_GTS, 5); map(ALU_GTU, 5); map(ALU_GES, 5); map(ALU_GEU, 5);
        map(ALU_EQ, 5); map(ALU_NE, 5);
        map(ALU_ABS, 6); map(ALU_CLIP, 6); map(ALU_CLIPU, 6);
        map(ALU_MIN, 7); map(ALU_MINU, 7); map(ALU_MAX, 7); map(ALU_MAXU, 7);
        map(ALU_DIVU, 8); map(ALU_DIV, 8); map(ALU_REMU, 8); map(ALU_REM, 8);
    endtask

    // Healthy ALUs of class c, lowest three kept; mode value equals lanes used.
    task automatic model_entry(input logic [3:0][8:0] f, input int c,
                               output logic [3:0] sel, output int mode);
        int h = 0;
        sel = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (!f[k][c]) begin
                if (h < 3) sel[k] = 1'b1;
                h++;
            end
        end
        mode = (h >= 3) ? 3 : h;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 9; c++) begin
            m_sel[c]  = 4'b0111;
            m_mode[c] = 3;
        end
        m_snap  = '0;
        m_busy  = 1'b0;
        m_rb    = -1;
        e_valid = 1'b0;
        e_sel   = 4'b0000;
        e_mode  = 0;
    endtask

    task automatic model_clock();
        bit chg;
        int c;
        chg     = (faulty != m_snap);
        e_valid = 1'b0;
        e_sel   = 4'b0000;
        e_mode  = 0;
        if (!m_busy && alu_if.alu_valid_i) begin
            c       = op_class[alu_if.alu_operator_i];
            e_valid = 1'b1;
            if (c == 9) begin
                e_sel  = 4'b0111;
                e_mode = 3;
            end else begin
                e_sel  = m_sel[c];
                e_mode = m_mode[c];
            end
        end
        if (chg) begin
            m_snap = faulty;
            if (!m_busy) begin
                m_busy = 1'b1;
                m_rb   = -1;
            end else if (m_rb >= 0) begin
                m_rb = 0;
            end
        end else if (m_busy) begin
            if (m_rb < 0) begin
                if (alu_if.pipe_idle_i) m_rb = 0;
            end else begin
                model_entry(m_snap, m_rb, m_sel[m_rb], m_mode[m_rb]);
                m_rb++;
                if (m_rb == 9) begin
                    m_busy = 1'b0;
                    m_rb   = -1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit any_none = 1'b0;
        for (int c = 0; c < 9; c++) if (m_mode[c] == 0) any_none = 1'b1;
        check("stall",     32'(alu_if.reconf_stall_o), 32'(m_busy));
        check("sel_valid", 32'(alu_if.sel_valid_o),    32'(e_valid));
        check("alu_sel",   32'(alu_if.alu_sel_o),      32'(e_sel));
        check("vote_mode", 32'(alu_if.vote_mode_o),    32'(e_mode));
        check("clock_en",  32'(alu_if.clock_en_o),     e_valid ? 32'(e_sel) : 32'd0);
        check("no_alu",    32'(no_alu),                32'(any_none));
    endtask

    // Called at a falling edge; inputs held across the next rising edge.
    task automatic step(input bit v, input logic [6:0] op, input bit idle);
        alu_if.alu_valid_i    = v;
        alu_if.alu_operator_i = op;
        alu_if.pipe_idle_i    = idle;
        model_clock();
        @(posedge clk);
        #1;
        check_outputs();
        if (alu_if.reconf_stall_o === 1'b1) stall_seen++;
        @(negedge clk);
    endtask

    task automatic wait_run();
        int n = 0;
        do begin
            step(1'b0, ALU_ADD, 1'b1);
            n++;
        end while (alu_if.reconf_stall_o !== 1'b0 && n < 40);
        check("rebuild_timeout", 32'(alu_if.reconf_stall_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                 = 1'b1;
        faulty                = '0;
        alu_if.alu_valid_i    = 1'b0;
        alu_if.alu_operator_i = '0;
        alu_if.pipe_idle_i    = 1'b1;
        init_map();
        model_reset();
        #2;
        do_reset();

        // Fault-free ADD
        step(1'b1, ALU_ADD, 1'b1);
        check("add_sel", 32'(alu_if.alu_sel_o), 32'h7);
        check("add_cen", 32'(alu_if.clock_en_o), 32'h7);

        // ALU1 faulty for logic ops, drain held five cycles
        faulty[1][1] = 1'b1;
        stall_seen   = 0;
        repeat (5) step(1'b0, ALU_ADD, 1'b0);
        wait_run();
        check("drain5_stall_cycles", stall_seen, 32'd14);
        step(1'b1, ALU_XOR, 1'b1);
        check("xor_sel", 32'(alu_if.alu_sel_o), 32'hd);
        check("xor_mode", 32'(alu_if.vote_mode_o), 32'(VOTE_TMR));
        step(1'b1, ALU_ADD, 1'b1);
        check("add_after_sel", 32'(alu_if.alu_sel_o), 32'h7);

        // Only ALU3 healthy for div/rem
        faulty[0][8] = 1'b1; faulty[1][8] = 1'b1; faulty[2][8] = 1'b1;
        stall_seen = 0;
        wait_run();
        check("div_stall_cycles", stall_seen, 32'd10);
        step(1'b1, ALU_DIV, 1'b1);
        check("div_sel", 32'(alu_if.alu_sel_o), 32'h8);
        check("div_mode", 32'(alu_if.vote_mode_o), 32'(VOTE_SINGLE));
        check("div_no_alu", 32'(no_alu), 32'd0);

        // No healthy ALU for comparisons
        for (int k = 0; k < 4; k++) faulty[k][5] = 1'b1;
        wait_run();
        step(1'b1, ALU_EQ, 1'b1);
        check("eq_sel", 32'(alu_if.alu_sel_o), 32'h0);
        check("eq_mode", 32'(alu_if.vote_mode_o), 32'(VOTE_NONE));
        check("eq_cen", 32'(alu_if.clock_en_o), 32'h0);
        check("eq_no_alu", 32'(no_alu), 32'd1);

        // Second fault lands while class 4 is next to be written
        faulty[0][0] = 1'b1;
        step(1'b0, ALU_ADD, 1'b1);
        step(1'b0, ALU_ADD, 1'b1);
        repeat (4) step(1'b0, ALU_ADD, 1'b1);
        faulty[2][2] = 1'b1;
        stall_seen   = 0;
        step(1'b0, ALU_ADD, 1'b1);
        wait_run();
        check("restart_stall_cycles", stall_seen, 32'd9);
        step(1'b1, ALU_ADD, 1'b1);
        check("restart_add_sel", 32'(alu_if.alu_sel_o), 32'he);
        step(1'b1, ALU_BSET, 1'b1);
        check("restart_bset_sel", 32'(alu_if.alu_sel_o), 32'hb);

        // Reset while class 3 is next to be written
        faulty[1][3] = 1'b1;
        step(1'b0, ALU_ADD, 1'b1);
        step(1'b0, ALU_ADD, 1'b1);
        repeat (3) step(1'b0, ALU_ADD, 1'b1);
        do_reset();
        check("rst_stall", 32'(alu_if.reconf_stall_o), 32'd0);
        stall_seen = 0;
        step(1'b1, ALU_ADD, 1'b1);
        check("rst_add_sel", 32'(alu_if.alu_sel_o), 32'h7);
        wait_run();
        check("rst_rebuild_stall_cycles", stall_seen, 32'd10);
        step(1'b1, ALU_CNT, 1'b1);
        check("rst_cnt_sel", 32'(alu_if.alu_sel_o), 32'hd);

        // Random traffic with sporadic fault flips
        for (int i = 0; i < 1500; i++) begin
            logic [6:0] op;
            if ($urandom_range(0, 59) == 0)
                faulty[$urandom_range(0, 3)][$urandom_range(0, 8)] ^= 1'b1;
            if ($urandom_range(0, 6) == 0) op = 7'($urandom_range(0, 127));
            else                           op = known[$urandom_range(0, known.size() - 1)];
            step($urandom_range(0, 3) != 0, op, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
